// File: rtl/sample_word_rx.sv
// sample_word_rx: 8N1 UART receiver that pairs bytes (low first, then high)
// into a 16-bit word, flagging bad stop bits and inter-byte timeouts.
module sample_word_rx #(
  parameter int unsigned CLK_FREQ     = 10000,
  parameter int unsigned BAUD         = 1000,
  parameter int unsigned TIMEOUT_CLKS = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [15:0] word_out,
  output logic        word_valid,
  output logic        frame_err,
  output logic        sync_err,
  output logic        busy
);

  localparam int unsigned CPB    = CLK_FREQ / BAUD;
  localparam int unsigned HALF   = CPB / 2;
  localparam int unsigned CNT_W  = $clog2(CPB + 1);
  localparam int unsigned TOUT_W = $clog2(TIMEOUT_CLKS + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} bit_state_t;
  typedef enum logic {AS_LO, AS_HI} asm_state_t;

  // synchroniser and edge-detect history
  logic r_sync1, r_sync2, r_rxs_d;
  logic w_start;

  // bit FSM
  bit_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bitn, w_bitn_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_byte_vld, w_byte_vld_nxt;
  logic             r_byte_bad, w_byte_bad_nxt;

  // assembler and outputs
  asm_state_t        r_asm, w_asm_nxt;
  logic [7:0]        r_lo, w_lo_nxt;
  logic [TOUT_W-1:0] r_tcnt, w_tcnt_nxt;
  logic [15:0]       r_word, w_word_nxt;
  logic              r_wv, w_wv_nxt;
  logic              r_fe, w_fe_nxt;
  logic              r_se, w_se_nxt;
  logic              r_busy;

  // Start edge: a 1->0 transition on the synchronised line, only seen from IDLE.
  assign w_start = (r_state == ST_IDLE) && r_rxs_d && !r_sync2;

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
      r_rxs_d <= r_sync2;
    end
  end

  // Bit FSM state register and byte-complete strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_bitn     <= '0;
      r_shift    <= '0;
      r_byte_vld <= 1'b0;
      r_byte_bad <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_bitn     <= w_bitn_nxt;
      r_shift    <= w_shift_nxt;
      r_byte_vld <= w_byte_vld_nxt;
      r_byte_bad <= w_byte_bad_nxt;
    end
  end

  // Bit FSM next state: the detect cycle counts toward the half-bit wait,
  // hence the HALF-2 preload.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_bitn_nxt     = r_bitn;
    w_shift_nxt    = r_shift;
    w_byte_vld_nxt = 1'b0;
    w_byte_bad_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = ST_START;
          w_cnt_nxt   = CNT_W'(HALF - 2);
          w_bitn_nxt  = '0;
        end
      end
      ST_START: begin
        if (r_cnt == '0) begin
          if (!r_sync2) begin
            w_state_nxt = ST_DATA;
            w_cnt_nxt   = CNT_W'(CPB - 1);
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (r_cnt == '0) begin
          w_shift_nxt = {r_sync2, r_shift[7:1]};
          w_cnt_nxt   = CNT_W'(CPB - 1);
          if (r_bitn == 3'd7) begin
            w_state_nxt = ST_STOP;
          end else begin
            w_bitn_nxt = r_bitn + 3'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (r_cnt == '0) begin
          w_state_nxt    = ST_IDLE;
          w_byte_vld_nxt = r_sync2;
          w_byte_bad_nxt = !r_sync2;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Assembler state, timeout counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_asm  <= AS_LO;
      r_lo   <= '0;
      r_tcnt <= '0;
      r_word <= '0;
      r_wv   <= 1'b0;
      r_fe   <= 1'b0;
      r_se   <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_asm  <= w_asm_nxt;
      r_lo   <= w_lo_nxt;
      r_tcnt <= w_tcnt_nxt;
      r_word <= w_word_nxt;
      r_wv   <= w_wv_nxt;
      r_fe   <= w_fe_nxt;
      r_se   <= w_se_nxt;
      r_busy <= (w_state_nxt != ST_IDLE) || (w_asm_nxt == AS_HI);
    end
  end

  // Assembler next state: byte events first, then the idle timeout
  // (a start edge in the same cycle suppresses the timeout).
  always_comb begin
    w_asm_nxt  = r_asm;
    w_lo_nxt   = r_lo;
    w_tcnt_nxt = r_tcnt;
    w_word_nxt = r_word;
    w_wv_nxt   = 1'b0;
    w_fe_nxt   = 1'b0;
    w_se_nxt   = 1'b0;
    if (r_byte_bad) begin
      w_fe_nxt  = 1'b1;
      w_asm_nxt = AS_LO;
    end else if (r_byte_vld) begin
      if (r_asm == AS_LO) begin
        w_lo_nxt  = r_shift;
        w_asm_nxt = AS_HI;
      end else begin
        w_word_nxt = {r_shift, r_lo};
        w_wv_nxt   = 1'b1;
        w_asm_nxt  = AS_LO;
      end
    end else if ((r_asm == AS_HI) && (r_state == ST_IDLE) && !w_start) begin
      if (r_tcnt == TOUT_W'(TIMEOUT_CLKS - 1)) begin
        w_se_nxt  = 1'b1;
        w_asm_nxt = AS_LO;
      end else begin
        w_tcnt_nxt = r_tcnt + TOUT_W'(1);
      end
    end
    if (w_start || (w_asm_nxt == AS_LO)) begin
      w_tcnt_nxt = '0;
    end
  end

  assign word_out   = r_word;
  assign word_valid = r_wv;
  assign frame_err  = r_fe;
  assign sync_err   = r_se;
  assign busy       = r_busy;

endmodule

// File: tb/tb_sample_word_rx.sv
// tb_sample_word_rx: directed vector table, hand-written corner sequences and
// a randomized byte stream checked against a pairing reference model.
module tb_sample_word_rx;

  localparam int unsigned CLK_FREQ     = 10000;
  localparam int unsigned BAUD         = 1000;
  localparam int unsigned TIMEOUT_CLKS = 300;
  localparam int CPB = int'(CLK_FREQ / BAUD);
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [15:0] word_out;
  logic        word_valid;
  logic        frame_err;
  logic        sync_err;
  logic        busy;

  sample_word_rx #(
    .CLK_FREQ    (CLK_FREQ),
    .BAUD        (BAUD),
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .word_out  (word_out),
    .word_valid(word_valid),
    .frame_err (frame_err),
    .sync_err  (sync_err),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int          wv_cnt = 0;
  int          fe_cnt = 0;
  int          se_cnt = 0;
  int          coinc_cnt = 0;
  int          last_wv_cyc = 0;
  logic [15:0] q_words[$];
  always @(negedge clk) begin
    if (word_valid === 1'b1) begin
      wv_cnt++;
      q_words.push_back(word_out);
      last_wv_cyc = cyc;
    end
    if (frame_err === 1'b1) fe_cnt++;
    if (sync_err === 1'b1) se_cnt++;
    if ((int'(word_valid === 1'b1) + int'(frame_err === 1'b1) + int'(sync_err === 1'b1)) > 1)
      coinc_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame; start_cyc is the cycle count when the start bit is driven.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int start_cyc);
    start_cyc = cyc;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " word_out"},   int'(word_out),   0);
    check({tag, " word_valid"}, int'(word_valid), 0);
    check({tag, " frame_err"},  int'(frame_err),  0);
    check({tag, " sync_err"},   int'(sync_err),   0);
    check({tag, " busy"},       int'(busy),       0);
  endtask

  typedef struct {
    int          n;
    logic [23:0] bytes;     // byte k at [8k +: 8], sent in order
    logic [2:0]  stops;     // stop bit value for byte k
    int          gap0;      // idle-high cycles after byte 0
    logic [15:0] exp_word;
    int          exp_wv;
    int          exp_fe;
    int          exp_se;
  } vec_t;

  typedef struct {
    logic [7:0] b;
    logic       ok;
    int         gap;
  } rbyte_t;

  vec_t        vecs[7];
  rbyte_t      stream[$];
  logic [15:0] mq[$];

  initial begin
    int b_wv, b_fe, b_se, b_co, b_q, sc, hi_cyc;
    int m_fe, m_se, kind;
    logic       pending;
    logic [7:0] m_lo;
    rbyte_t     e;

    vecs[0] = '{2, 24'h00F00F, 3'b111, 0,   16'hF00F, 1, 0, 0};
    vecs[1] = '{2, 24'h001234, 3'b111, 0,   16'h1234, 1, 0, 0};
    vecs[2] = '{3, 24'h8001FF, 3'b110, 20,  16'h8001, 1, 1, 0};
    vecs[3] = '{3, 24'h6655AA, 3'b111, 400, 16'h6655, 1, 0, 1};
    vecs[4] = '{2, 24'h005AC3, 3'b111, 250, 16'h5AC3, 1, 0, 0};
    vecs[5] = '{2, 24'h009977, 3'b101, 0,   16'h5AC3, 0, 1, 0};
    vecs[6] = '{2, 24'h00FF00, 3'b111, 0,   16'hFF00, 1, 0, 0};

    // Reset and long idle.
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    idle(500);
    check("idle word_valid count", wv_cnt, 0);
    check("idle frame_err count", fe_cnt, 0);
    check("idle sync_err count", se_cnt, 0);
    check_outputs_zero("idle");

    // Short low glitch on the idle line.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(50);
    check("glitch word_valid count", wv_cnt, 0);
    check("glitch frame_err count", fe_cnt, 0);
    check("glitch sync_err count", se_cnt, 0);
    check("glitch busy", int'(busy), 0);

    // Directed vector table.
    for (int v = 0; v < 7; v++) begin
      b_wv = wv_cnt; b_fe = fe_cnt; b_se = se_cnt; b_co = coinc_cnt; b_q = q_words.size();
      hi_cyc = 0;
      for (int k = 0; k < vecs[v].n; k++) begin
        send_byte(vecs[v].bytes[8*k +: 8], vecs[v].stops[k], sc);
        hi_cyc = sc;
        if (k == 0) idle(vecs[v].gap0);
      end
      idle(40);
      check($sformatf("vec%0d word_valid count", v), wv_cnt - b_wv, vecs[v].exp_wv);
      check($sformatf("vec%0d frame_err count", v), fe_cnt - b_fe, vecs[v].exp_fe);
      check($sformatf("vec%0d sync_err count", v), se_cnt - b_se, vecs[v].exp_se);
      check($sformatf("vec%0d coincident pulses", v), coinc_cnt - b_co, 0);
      check($sformatf("vec%0d word_out", v), int'(word_out), int'(vecs[v].exp_word));
      check($sformatf("vec%0d busy", v), int'(busy), 0);
      if (vecs[v].exp_wv == 1 && q_words.size() > b_q) begin
        check($sformatf("vec%0d pulsed word", v), int'(q_words[b_q]), int'(vecs[v].exp_word));
        check($sformatf("vec%0d latency", v), last_wv_cyc - hi_cyc, LAT);
      end
    end

    // Reset during the data bits of a high byte discards the pending low byte.
    b_wv = wv_cnt; b_fe = fe_cnt; b_se = se_cnt;
    send_byte(8'h5C, 1'b1, sc);
    rx = 1'b0;
    repeat (CPB + 35) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    check_outputs_zero("midreset");
    rst = 1'b0;
    idle(40);
    check("midreset word_valid count", wv_cnt - b_wv, 0);
    check("midreset frame_err count", fe_cnt - b_fe, 0);
    check("midreset sync_err count", se_cnt - b_se, 0);
    check_outputs_zero("midreset idle");
    b_q = q_words.size();
    send_byte(8'h11, 1'b1, sc);
    send_byte(8'h22, 1'b1, hi_cyc);
    idle(40);
    check("midreset recovery word_valid count", wv_cnt - b_wv, 1);
    check("midreset recovery word_out", int'(word_out), 16'h2211);
    if (q_words.size() > b_q)
      check("midreset recovery latency", last_wv_cyc - hi_cyc, LAT);

    // Randomized stream: well-formed pairs, bad-stop bytes and timed-out low bytes.
    for (int t = 0; t < 30; t++) begin
      kind = int'($urandom_range(0, 2));
      if (kind == 1) begin
        e.b = 8'($urandom); e.ok = 1'b0; e.gap = int'($urandom_range(5, 200));
        stream.push_back(e);
      end else if (kind == 2) begin
        e.b = 8'($urandom); e.ok = 1'b1; e.gap = int'($urandom_range(350, 420));
        stream.push_back(e);
      end
      e.b = 8'($urandom); e.ok = 1'b1; e.gap = int'($urandom_range(0, 200));
      stream.push_back(e);
      e.b = 8'($urandom); e.ok = 1'b1; e.gap = int'($urandom_range(0, 200));
      stream.push_back(e);
    end

    // Reference model: pair good bytes, drop the pending low byte on a bad
    // stop bit or when the following idle gap reaches the timeout.
    pending = 1'b0; m_lo = '0; m_fe = 0; m_se = 0;
    foreach (stream[i]) begin
      if (!stream[i].ok) begin
        m_fe++;
        pending = 1'b0;
      end else if (pending) begin
        mq.push_back({stream[i].b, m_lo});
        pending = 1'b0;
      end else begin
        m_lo = stream[i].b;
        pending = 1'b1;
      end
      if (pending && stream[i].gap >= int'(TIMEOUT_CLKS)) begin
        m_se++;
        pending = 1'b0;
      end
    end

    b_wv = wv_cnt; b_fe = fe_cnt; b_se = se_cnt; b_co = coinc_cnt; b_q = q_words.size();
    foreach (stream[i]) begin
      send_byte(stream[i].b, stream[i].ok, sc);
      idle(stream[i].gap);
    end
    idle(40);
    check("random word count", wv_cnt - b_wv, mq.size());
    check("random frame_err count", fe_cnt - b_fe, m_fe);
    check("random sync_err count", se_cnt - b_se, m_se);
    check("random coincident pulses", coinc_cnt - b_co, 0);
    check("random busy", int'(busy), 0);
    foreach (mq[i]) begin
      if (b_q + i < q_words.size())
        check($sformatf("random word %0d", i), int'(q_words[b_q + i]), int'(mq[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sample_word_rx.md
Name: sample_word_rx

Overview:
- Host-side receiver that is the far end of the sensor's UART transmit path.
- Deserialises the 8N1 serial stream and pairs consecutive bytes into the 16-bit average word: low byte first, then high byte.
- Presents each word with a one-cycle valid strobe and flags framing and resynchronisation errors.
- Used in the bench/FPGA companion design and as the checker for the send-data path.

Parameters:
- CLK_FREQ, 10000, clock frequency in Hz.
- BAUD, 1000, serial bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD, must be at least 4 (default 10).
- TIMEOUT_CLKS, 300, maximum idle clocks allowed between the low byte's stop sample and the high byte's start edge.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- rx  in  1  serial input, idle high
- word_out  out  16  last assembled word, {high, low}
- word_valid  out  1  one-cycle pulse when word_out is updated
- frame_err  out  1  one-cycle pulse on a bad stop bit
- sync_err  out  1  one-cycle pulse on an inter-byte timeout
- busy  out  1  high while a frame is in progress or a low byte is pending

Behaviour:
- Reset: synchronous, active-high, takes priority over everything.
  - All outputs are 0 after reset.
  - Bit FSM returns to IDLE, assembler returns to EXPECT_LO, timeout counter clears.
  - Synchroniser flops are set to 1.
  - Asserting rst mid-frame discards the partial byte and any pending low byte.
- Input: rx passes through a 2-flop synchroniser. All decisions use the synchronised value rxs. This adds 2 cycles of fixed latency.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE: a 1->0 transition on rxs loads the bit counter and goes to START.
  - START: after CLKS_PER_BIT/2 cycles, sample rxs.
    - If rxs is 0, go to DATA.
    - If rxs is 1, treat it as a glitch and return to IDLE with no flag.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first into a shift register, then go to STOP.
  - STOP: after CLKS_PER_BIT cycles, sample rxs.
    - If rxs is 1, the byte is good.
    - If rxs is 0, pulse frame_err for one cycle, discard the byte, and force the assembler to EXPECT_LO.
    - In both cases, return to IDLE immediately; waiting for the line to go high is not required.
  - A start edge can only be detected from IDLE.
- Assembler states: EXPECT_LO, EXPECT_HI.
  - Good byte in EXPECT_LO: latch it as lo and go to EXPECT_HI.
  - Good byte in EXPECT_HI, on the cycle after the stop sample:
    - word_out <= {byte, lo};
    - word_valid pulses for 1 cycle;
    - go to EXPECT_LO.
  - word_out holds its value between pulses.
- Timeout:
  - In EXPECT_HI with the bit FSM in IDLE, a counter increments every cycle.
  - When the count reaches TIMEOUT_CLKS, sync_err pulses for one cycle, lo is discarded, and the assembler goes to EXPECT_LO.
  - The counter clears on any start edge and on leaving EXPECT_HI.
  - If a start edge and the timeout occur in the same cycle, the start edge wins (no sync_err).
- Simultaneous events: frame_err and sync_err can never assert in the same cycle. word_valid and either error never coincide.
- busy = (bit FSM not in IDLE) OR (assembler in EXPECT_HI).
- Latency: word_valid rises 2 (sync) + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the high byte's start edge on rx. With defaults this is 2+5+90+1 = 98 cycles.

Test Plan:
- Reset, then rx idle high for 500 cycles -> all outputs stay 0, no pulses.
- Send byte 0x34, then byte 0x12 back-to-back at 10 clk/bit -> exactly one word_valid pulse with word_out = 0x1234, 98 cycles after the 0x12 start edge, busy = 0 afterwards.
- Send 0xFF with the stop bit forced to 0, then 0x01 and 0x80 -> one frame_err pulse, then word_valid with word_out = 0x8001, with no stale 0xFF in the word.
- Send 0xAA, hold rx high for 300+ cycles, then send 0x55 and 0x66 -> sync_err pulses once at the timeout, then word_out = 0x6655; 0xAA never appears.
- Drive a 3-cycle low glitch on idle rx -> no error and no valid pulse; a following 0x0F, 0xF0 pair yields 0xF00F.
- Assert rst for 1 cycle during DATA of a high byte, then send 0x11, 0x22 -> outputs 0 after reset, then word_out = 0x2211 with no pulse for the aborted frame.
